// File: rtl/binned_projection_histogram.sv
// binned_projection_histogram: binned x/y projection counts with saturation, peak tracking, clear sweep and readout
module binned_projection_histogram #(
  parameter int IMAGE_WIDTH  = 240,
  parameter int IMAGE_HEIGHT = 180,
  parameter int ADDR_WIDTH   = 8,
  parameter int BIN_SHIFT    = 0,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   pixelValid,
  input  logic [ADDR_WIDTH-1:0]  xAddress,
  input  logic [ADDR_WIDTH-1:0]  yAddress,
  input  logic                   pixelData,
  input  logic                   readHistogram,
  input  logic                   clearHistogram,
  output logic [COUNT_WIDTH-1:0] xHistogramOut,
  output logic [COUNT_WIDTH-1:0] yHistogramOut,
  output logic [ADDR_WIDTH-1:0]  binIndex,
  output logic                   xValid,
  output logic                   yValid,
  output logic                   readDone,
  output logic [ADDR_WIDTH-1:0]  peakX,
  output logic [ADDR_WIDTH-1:0]  peakY,
  output logic                   peakValid,
  output logic                   overflow,
  output logic                   histogramClear,
  output logic                   ready
);
  localparam int X_BINS = (IMAGE_WIDTH + (1 << BIN_SHIFT) - 1) >> BIN_SHIFT;
  localparam int Y_BINS = (IMAGE_HEIGHT + (1 << BIN_SHIFT) - 1) >> BIN_SHIFT;
  localparam int CLR_BINS = X_BINS > Y_BINS ? X_BINS : Y_BINS;
  localparam int XW = X_BINS > 1 ? $clog2(X_BINS) : 1;
  localparam int YW = Y_BINS > 1 ? $clog2(Y_BINS) : 1;
  localparam logic [ADDR_WIDTH-1:0] X_LAST = ADDR_WIDTH'(X_BINS - 1);
  localparam logic [ADDR_WIDTH-1:0] Y_LAST = ADDR_WIDTH'(Y_BINS - 1);
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(CLR_BINS - 1);
  localparam logic [ADDR_WIDTH:0] X_LIM = (ADDR_WIDTH + 1)'(IMAGE_WIDTH);
  localparam logic [ADDR_WIDTH:0] Y_LIM = (ADDR_WIDTH + 1)'(IMAGE_HEIGHT);

  typedef enum logic [2:0] {CLEAR, IDLE, ACCUM, DONE, READ_X, READ_Y} state_t;

  state_t state, stNext;
  logic [ADDR_WIDTH-1:0] idx, idxNext, xb, yb;
  logic [COUNT_WIDTH-1:0] xBin [X_BINS];
  logic [COUNT_WIDTH-1:0] yBin [Y_BINS];
  logic [COUNT_WIDTH-1:0] xCnt, yCnt, xPeakCnt, yPeakCnt;
  logic xHit, yHit, xSat, ySat;

  assign ready = state == IDLE;

  // Decode the incoming pixel into per-axis bin hits; x and y ranges are checked independently
  always_comb begin
    xb = xAddress >> BIN_SHIFT;
    yb = yAddress >> BIN_SHIFT;
    xHit = state == ACCUM && pixelValid && pixelData && {1'b0, xAddress} < X_LIM;
    yHit = state == ACCUM && pixelValid && pixelData && {1'b0, yAddress} < Y_LIM;
    xCnt = xBin[xb[XW-1:0]];
    yCnt = yBin[yb[YW-1:0]];
    xSat = &xCnt;
    ySat = &yCnt;
  end

  // Next state and sweep/readout index; a clear beats a read when both arrive in DONE
  always_comb begin
    stNext = state;
    idxNext = idx;
    unique case (state)
      CLEAR: begin
        stNext = idx == CLR_LAST ? IDLE : CLEAR;
        idxNext = idx == CLR_LAST ? '0 : idx + 1'b1;
      end
      IDLE: begin
        stNext = clearHistogram ? CLEAR : start ? ACCUM : IDLE;
        idxNext = '0;
      end
      ACCUM: stNext = stop ? DONE : ACCUM;
      DONE: begin
        stNext = clearHistogram ? CLEAR : readHistogram ? READ_X : DONE;
        idxNext = '0;
      end
      READ_X: begin
        stNext = idx == X_LAST ? READ_Y : READ_X;
        idxNext = idx == X_LAST ? '0 : idx + 1'b1;
      end
      READ_Y: begin
        stNext = idx == Y_LAST ? DONE : READ_Y;
        idxNext = idx == Y_LAST ? '0 : idx + 1'b1;
      end
      default: begin
        stNext = CLEAR;
        idxNext = '0;
      end
    endcase
  end

  // State, registered readout outputs (driven from the next bin so data lines up with the state), peaks and overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      idx <= '0;
      xHistogramOut <= '0;
      yHistogramOut <= '0;
      binIndex <= '0;
      xValid <= 1'b0;
      yValid <= 1'b0;
      readDone <= 1'b0;
      histogramClear <= 1'b0;
      peakX <= '0;
      peakY <= '0;
      xPeakCnt <= '0;
      yPeakCnt <= '0;
      peakValid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= stNext;
      idx <= idxNext;
      xValid <= stNext == READ_X;
      yValid <= stNext == READ_Y;
      xHistogramOut <= stNext == READ_X ? xBin[idxNext[XW-1:0]] : '0;
      yHistogramOut <= stNext == READ_Y ? yBin[idxNext[YW-1:0]] : '0;
      binIndex <= (stNext == READ_X || stNext == READ_Y) ? idxNext : '0;
      readDone <= stNext == READ_Y && idxNext == Y_LAST;
      histogramClear <= stNext == CLEAR && idxNext == CLR_LAST;
      if (state == CLEAR) begin
        peakX <= '0;
        peakY <= '0;
        xPeakCnt <= '0;
        yPeakCnt <= '0;
        peakValid <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (xHit && !xSat && xCnt + 1'b1 > xPeakCnt) begin
          peakX <= xb;
          xPeakCnt <= xCnt + 1'b1;
        end
        if (yHit && !ySat && yCnt + 1'b1 > yPeakCnt) begin
          peakY <= yb;
          yPeakCnt <= yCnt + 1'b1;
        end
        if ((xHit && xSat) || (yHit && ySat)) overflow <= 1'b1;
        if (xHit || yHit) peakValid <= 1'b1;
      end
    end
  end

  // Bin storage has no reset: the clear sweep zeroes bin k on sweep cycle k, accumulation saturates
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      if (idx <= X_LAST) xBin[idx[XW-1:0]] <= '0;
      if (idx <= Y_LAST) yBin[idx[YW-1:0]] <= '0;
    end else begin
      if (xHit && !xSat) xBin[xb[XW-1:0]] <= xCnt + 1'b1;
      if (yHit && !ySat) yBin[yb[YW-1:0]] <= yCnt + 1'b1;
    end
  end
endmodule
